// File: rtl/conv_result_writer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_result_writer_if : result stream in, shared memory write port out |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface conv_result_writer_if #(
   parameter int DW = 19,
   parameter int MW = 20,
   parameter int AW = 12
);
   logic          i_start;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_wr;
   logic          o_sel;
   logic [AW-1:0] o_addr;
   logic [MW-1:0] o_data;
   logic          o_busy;
   logic          o_done;
   logic          o_overflow;

   modport master (
      output i_start, i_valid, i_data,
      input  o_wr, o_sel, o_addr, o_data, o_busy, o_done, o_overflow
   );

   modport slave (
      input  i_start, i_valid, i_data,
      output o_wr, o_sel, o_addr, o_data, o_busy, o_done, o_overflow
   );
endinterface
`default_nettype wire

// File: rtl/conv_result_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_result_writer : ReLU, layer-0 store and 2x2 max-pooled layer-1   |
// | store through one shared write port. Rev 1.0                          |
// +-----------------------------------------------------------------------+
module conv_result_writer #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int DW     = 19,
   parameter int MW     = 20,
   parameter int AW     = 12,
   parameter int QDEPTH = 4
) (
   input  wire logic           clk,
   input  wire logic           reset,
   conv_result_writer_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int QW = $clog2(QDEPTH);
   localparam int LB = IMG_W / 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  col_q, col_d;
   logic [RW-1:0]  row_q, row_d;
   logic [MW-1:0]  hold_q, hold_d;
   logic [MW-1:0]  linebuf_q [LB];
   logic [MW-1:0]  linebuf_d [LB];

   logic           v1_q, v1_d;
   logic [MW-1:0]  r1_q, r1_d;
   logic [AW-1:0]  a1_q, a1_d;

   logic           push_q, push_d;
   logic [MW-1:0]  pdata_q, pdata_d;
   logic [AW-1:0]  paddr_q, paddr_d;

   logic [MW-1:0]  qdata_q [QDEPTH];
   logic [MW-1:0]  qdata_d [QDEPTH];
   logic [AW-1:0]  qaddr_q [QDEPTH];
   logic [AW-1:0]  qaddr_d [QDEPTH];
   logic [QW-1:0]  wptr_q, wptr_d;
   logic [QW-1:0]  rptr_q, rptr_d;
   logic [QW:0]    count_q, count_d;

   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           ovf_q, ovf_d;

   logic           accept;
   logic           stray;
   logic           pop;
   logic           full;
   logic           do_push;
   logic [MW-1:0]  relu;
   logic [CW-2:0]  lb_idx;
   logic [MW-1:0]  lb_rd;
   logic [MW-1:0]  pool_p;
   logic [MW-1:0]  pool_m;

   assign accept  = (state_q == S_RUN) && bus.i_valid;
   assign stray   = (state_q != S_RUN) && bus.i_valid;
   assign relu    = bus.i_data[DW-1] ? '0 : {{(MW-DW+1){1'b0}}, bus.i_data[DW-2:0]};
   assign lb_idx  = col_q[CW-1:1];
   assign lb_rd   = linebuf_q[lb_idx];
   assign pool_p  = (hold_q > relu) ? hold_q : relu;
   assign pool_m  = (lb_rd > pool_p) ? lb_rd : pool_p;

   // Layer-0 traffic owns the port; the queue only drains into free cycles.
   assign pop     = !v1_q && (count_q != '0);
   assign full    = (count_q == (QW+1)'(QDEPTH));
   assign do_push = push_q && (!full || pop);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      hold_d    = hold_q;
      linebuf_d = linebuf_q;
      qdata_d   = qdata_q;
      qaddr_d   = qaddr_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;

      v1_d    = accept;
      r1_d    = relu;
      a1_d    = AW'({row_q, col_q});
      push_d  = accept && col_q[0] && row_q[0];
      pdata_d = pool_m;
      paddr_d = AW'({row_q[RW-1:1], col_q[CW-1:1]});

      if (accept) begin
         if (!col_q[0]) begin
            hold_d = relu;
         end else if (!row_q[0]) begin
            linebuf_d[lb_idx] = pool_p;
         end
         if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      if (do_push) begin
         qdata_d[wptr_q] = pdata_q;
         qaddr_d[wptr_q] = paddr_q;
         wptr_d          = wptr_q + QW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + QW'(1);
      end
      case ({do_push, pop})
         2'b10:   count_d = count_q + (QW+1)'(1);
         2'b01:   count_d = count_q - (QW+1)'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
               busy_d  = 1'b1;
               ovf_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (accept && (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // count_d already reflects this cycle's push and pop.
            if (count_d == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if ((push_q && full && !pop) || stray) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         hold_q    <= '0;
         linebuf_q <= '{default: '0};
         v1_q      <= 1'b0;
         r1_q      <= '0;
         a1_q      <= '0;
         push_q    <= 1'b0;
         pdata_q   <= '0;
         paddr_q   <= '0;
         qdata_q   <= '{default: '0};
         qaddr_q   <= '{default: '0};
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         hold_q    <= hold_d;
         linebuf_q <= linebuf_d;
         v1_q      <= v1_d;
         r1_q      <= r1_d;
         a1_q      <= a1_d;
         push_q    <= push_d;
         pdata_q   <= pdata_d;
         paddr_q   <= paddr_d;
         qdata_q   <= qdata_d;
         qaddr_q   <= qaddr_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.o_wr       = v1_q | pop;
   assign bus.o_sel      = pop;
   assign bus.o_addr     = v1_q ? a1_q : (pop ? qaddr_q[rptr_q] : '0);
   assign bus.o_data     = v1_q ? r1_q : (pop ? qdata_q[rptr_q] : '0);
   assign bus.o_busy     = busy_q;
   assign bus.o_done     = done_q;
   assign bus.o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_conv_result_writer : directed frames against a result memory model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_conv_result_writer;
   localparam int IMG_W  = 64;
   localparam int IMG_H  = 64;
   localparam int DW     = 19;
   localparam int MW     = 20;
   localparam int AW     = 12;
   localparam int QDEPTH = 4;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int NL1    = NPIX / 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   conv_result_writer_if #(.DW(DW), .MW(MW), .AW(AW)) bus ();

   conv_result_writer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .MW(MW), .AW(AW), .QDEPTH(QDEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [MW-1:0] mem0 [NPIX];
   logic [MW-1:0] mem1 [NL1];
   int            ep0  [NPIX];
   int            ep1  [NL1];
   int            epoch = 0;
   int            wcnt0 = 0;
   int            wcnt1 = 0;
   int            done_cnt = 0;
   int            cyc = 0;
   int            last_l1_cyc = 0;
   int            done_cyc = 0;
   int            checks = 0;
   int            failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Result memory model: records every write seen on the shared port.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.o_wr) begin
            if (bus.o_sel) begin
               mem1[bus.o_addr[9:0]] <= bus.o_data;
               ep1[bus.o_addr[9:0]]  <= epoch;
               wcnt1                 <= wcnt1 + 1;
               last_l1_cyc           <= cyc;
            end else begin
               mem0[bus.o_addr] <= bus.o_data;
               ep0[bus.o_addr]  <= epoch;
               wcnt0            <= wcnt0 + 1;
            end
         end
         if (bus.o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pix(input int kind, input int idx);
      if (kind == 0) return DW'(idx % 262144);
      if (kind == 1) return 19'h7FFFF;
      case (idx)
         0:       return 19'd5;
         1:       return 19'h7FFFD;
         64:      return 19'd7;
         65:      return 19'd2;
         default: return 19'd0;
      endcase
   endfunction

   function automatic logic [MW-1:0] relu_ref(input logic [DW-1:0] v);
      return v[DW-1] ? '0 : MW'(v);
   endfunction

   function automatic logic [MW-1:0] max2(input logic [MW-1:0] a, input logic [MW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic start_frame();
      epoch++;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   // Gapped mode: 8 valid cycles followed by 4 idle cycles.
   task automatic feed(input int kind, input bit gapped, input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_valid = 1'b1;
         bus.i_data  = pix(kind, i);
         tick();
         if (gapped && (i % 8 == 7)) begin
            bus.i_valid = 1'b0;
            repeat (4) tick();
         end
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_done(input int base, input string tag);
      int n = 0;
      while (done_cnt == base && n < 20000) begin
         tick();
         n++;
      end
      check(tag, 64'(done_cnt != base), 64'd1);
      repeat (3) tick();
   endtask

   task automatic verify_l0(input int kind, input string tag);
      int bad = 0;
      int first = -1;
      for (int a = 0; a < NPIX; a++) begin
         if (ep0[a] != epoch || mem0[a] !== relu_ref(pix(kind, a))) begin
            bad++;
            if (first < 0) first = a;
         end
      end
      check(tag, 64'(bad), 64'd0);
      if (bad != 0) $display("  first bad layer-0 address %0d", first);
   endtask

   task automatic verify_l1(input int kind, input string tag);
      int bad = 0;
      int first = -1;
      for (int k = 0; k < NL1; k++) begin
         int b;
         logic [MW-1:0] e;
         b = (k / 32) * 2 * IMG_W + (k % 32) * 2;
         e = max2(max2(relu_ref(pix(kind, b)), relu_ref(pix(kind, b + 1))),
                  max2(relu_ref(pix(kind, b + IMG_W)), relu_ref(pix(kind, b + IMG_W + 1))));
         if (ep1[k] != epoch || mem1[k] !== e) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      check(tag, 64'(bad), 64'd0);
      if (bad != 0) $display("  first bad layer-1 address %0d", first);
   endtask

   initial begin
      int w0, w1, d0;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      for (int a = 0; a < NPIX; a++) ep0[a] = 0;
      for (int k = 0; k < NL1; k++) ep1[k] = 0;

      repeat (3) tick();
      check("reset_outputs",
            64'({bus.o_wr, bus.o_sel, bus.o_addr, bus.o_data, bus.o_busy, bus.o_done, bus.o_overflow}),
            64'd0);
      reset = 1'b0;
      tick();

      // Frame A: back-to-back inputs; queue holds only the first four pooled words.
      w0 = wcnt0; w1 = wcnt1; d0 = done_cnt;
      start_frame();
      check("busy_after_start", 64'(bus.o_busy), 64'd1);
      feed(0, 1'b0, NPIX);
      wait_done(d0, "A_done_seen");
      verify_l0(0, "A_l0_content");
      check("A_l0_count", 64'(wcnt0 - w0), 64'(NPIX));
      check("A_l1_count", 64'(wcnt1 - w1), 64'd4);
      check("A_l1_addr3", 64'(mem1[3]), 64'd71);
      check("A_overflow", 64'(bus.o_overflow), 64'd1);
      check("A_busy_low", 64'(bus.o_busy), 64'd0);

      // Frame B: gapped inputs leave room to drain every pooled word.
      w0 = wcnt0; w1 = wcnt1; d0 = done_cnt;
      start_frame();
      check("B_ovf_cleared", 64'(bus.o_overflow), 64'd0);
      feed(0, 1'b1, NPIX);
      wait_done(d0, "B_done_seen");
      verify_l0(0, "B_l0_content");
      verify_l1(0, "B_l1_content");
      check("B_l1_0", 64'(mem1[0]), 64'd65);
      check("B_l1_1023", 64'(mem1[1023]), 64'd4095);
      check("B_l1_count", 64'(wcnt1 - w1), 64'(NL1));
      check("B_overflow", 64'(bus.o_overflow), 64'd0);
      check("B_done_once", 64'(done_cnt - d0), 64'd1);
      check("B_done_timing", 64'(done_cyc - last_l1_cyc), 64'd1);
      check("B_busy_low", 64'(bus.o_busy), 64'd0);

      // All negative inputs clamp to zero in both maps.
      d0 = done_cnt;
      start_frame();
      feed(1, 1'b1, NPIX);
      wait_done(d0, "N_done_seen");
      verify_l0(1, "N_l0_zero");
      verify_l1(1, "N_l1_zero");

      // Single mixed-sign block in the top-left corner.
      d0 = done_cnt;
      start_frame();
      feed(2, 1'b1, NPIX);
      wait_done(d0, "K_done_seen");
      check("K_l0_0", 64'(mem0[0]), 64'd5);
      check("K_l0_1", 64'(mem0[1]), 64'd0);
      check("K_l0_64", 64'(mem0[64]), 64'd7);
      check("K_l0_65", 64'(mem0[65]), 64'd2);
      check("K_l1_0", 64'(mem1[0]), 64'd7);

      // Stray valid in IDLE.
      w0 = wcnt0; w1 = wcnt1;
      bus.i_valid = 1'b1;
      bus.i_data  = 19'd123;
      tick();
      bus.i_valid = 1'b0;
      repeat (3) tick();
      check("I_no_write", 64'((wcnt0 - w0) + (wcnt1 - w1)), 64'd0);
      check("I_overflow", 64'(bus.o_overflow), 64'd1);
      start_frame();
      check("I_ovf_cleared", 64'(bus.o_overflow), 64'd0);

      // Abort the frame with reset while a write is on the port.
      feed(0, 1'b0, 1999);
      bus.i_valid = 1'b1;
      bus.i_data  = pix(0, 1999);
      check("R_wr_before", 64'(bus.o_wr), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("R_outputs_zero",
            64'({bus.o_wr, bus.o_sel, bus.o_addr, bus.o_data, bus.o_busy, bus.o_done, bus.o_overflow}),
            64'd0);
      bus.i_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();

      w0 = wcnt0; w1 = wcnt1; d0 = done_cnt;
      start_frame();
      feed(0, 1'b1, NPIX);
      wait_done(d0, "F_done_seen");
      verify_l0(0, "F_l0_content");
      verify_l1(0, "F_l1_content");
      check("F_l0_count", 64'(wcnt0 - w0), 64'(NPIX));
      check("F_overflow", 64'(bus.o_overflow), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
